// File: rtl/alu8_operand_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : alu8_operand_sequencer_if
// Purpose  : Handshake bundle for the ALU8 operand sequencer. Carries the
//            upstream byte stream (in_*) and the downstream result
//            stream (res_*).
// Modports : slave  - the sequencer (consumes bytes, produces results)
//            master - the environment (produces bytes, consumes results)
// Signals  : in_valid/in_ready/in_data/in_mode  byte channel
//            res_valid/res_ready/res_data/res_zero  result channel
// Revision : 1.0 - initial release
// ============================================================================
interface alu8_operand_sequencer_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_mode;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_zero;

  modport slave (
    input  in_valid, in_data, in_mode, res_ready,
    output in_ready, res_valid, res_data, res_zero
  );

  modport master (
    output in_valid, in_data, in_mode, res_ready,
    input  in_ready, res_valid, res_data, res_zero
  );
endinterface
`default_nettype wire

// File: rtl/alu8_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu8_operand_sequencer
// Purpose  : Assembles left operand, right operand and mode from a byte
//            stream, drives them to the combinational ALU8, captures its
//            result one cycle later and offers it downstream with a zero
//            flag. One operation in flight at a time.
// Ports    : clk        - clock, all state on posedge
//            reset_bar  - synchronous active-low reset
//            clear      - synchronous abort back to S_LEFT
//            bus        - byte/result handshakes (slave modport)
//            alu_left   - ALU8 left operand
//            alu_right  - ALU8 right operand
//            alu_mode   - ALU8 mode
//            alu_result - ALU8 combinational result
//            busy       - operation in progress (S_RIGHT/S_EXEC/S_DONE)
//            op_count   - completed operations, modulo 256
// Revision : 1.0 - initial release
// ============================================================================
module alu8_operand_sequencer #(
  parameter int DATA_W = 8
) (
  input  wire                       clk,
  input  wire                       reset_bar,
  input  wire                       clear,
  alu8_operand_sequencer_if.slave   bus,
  output logic [DATA_W-1:0]         alu_left,
  output logic [DATA_W-1:0]         alu_right,
  output logic [1:0]                alu_mode,
  input  wire  [DATA_W-1:0]         alu_result,
  output logic                      busy,
  output logic [7:0]                op_count
);

  typedef enum logic [1:0] {
    S_LEFT  = 2'd0,
    S_RIGHT = 2'd1,
    S_EXEC  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_alu_left;
  logic [DATA_W-1:0] r_alu_right;
  logic [1:0]        r_alu_mode;
  logic [DATA_W-1:0] r_res_data;
  logic              r_res_zero;
  logic [7:0]        r_op_count;

  // Handshake flags are pure state decodes, so neither in_valid nor
  // res_ready can reach an output combinationally.
  assign bus.in_ready  = (r_state == S_LEFT) || (r_state == S_RIGHT);
  assign bus.res_valid = (r_state == S_DONE);
  assign bus.res_data  = r_res_data;
  assign bus.res_zero  = r_res_zero;
  assign busy          = (r_state != S_LEFT);
  assign alu_left      = r_alu_left;
  assign alu_right     = r_alu_right;
  assign alu_mode      = r_alu_mode;
  assign op_count      = r_op_count;

  always_ff @(posedge clk) begin
    if (!reset_bar) begin
      r_state     <= S_LEFT;
      r_alu_left  <= '0;
      r_alu_right <= '0;
      r_alu_mode  <= 2'd0;
      r_res_data  <= '0;
      r_res_zero  <= 1'b0;
      r_op_count  <= 8'd0;
    end else if (clear) begin
      // Abort only: datapath registers and the counter keep their values,
      // and a pending result is dropped without being counted.
      r_state <= S_LEFT;
    end else begin
      case (r_state)
        S_LEFT: begin
          if (bus.in_valid) begin
            r_alu_left <= bus.in_data;
            r_state    <= S_RIGHT;
          end
        end
        S_RIGHT: begin
          if (bus.in_valid) begin
            r_alu_right <= bus.in_data;
            r_alu_mode  <= bus.in_mode;
            r_state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Operands have been stable for the whole cycle; the ALU
          // output is settled by this edge.
          r_res_data <= alu_result;
          r_res_zero <= (alu_result == '0);
          r_state    <= S_DONE;
        end
        S_DONE: begin
          if (bus.res_ready) begin
            r_op_count <= r_op_count + 8'd1;
            r_state    <= S_LEFT;
          end
        end
        default: r_state <= S_LEFT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu8_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu8_operand_sequencer
// Purpose  : Directed self-checking bench for alu8_operand_sequencer. A small
//            ALU8 stand-in (0:AND 1:OR 2:ADD 3:SUB, carry dropped) closes the
//            loop on alu_result.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu8_operand_sequencer;

  logic       clk;
  logic       reset_bar;
  logic       clear;
  logic [7:0] alu_left;
  logic [7:0] alu_right;
  logic [1:0] alu_mode;
  logic [7:0] alu_result;
  logic       busy;
  logic [7:0] op_count;

  int n_tests;
  int n_fail;

  alu8_operand_sequencer_if #(.DATA_W(8)) bus ();

  alu8_operand_sequencer #(.DATA_W(8)) dut (
    .clk        (clk),
    .reset_bar  (reset_bar),
    .clear      (clear),
    .bus        (bus),
    .alu_left   (alu_left),
    .alu_right  (alu_right),
    .alu_mode   (alu_mode),
    .alu_result (alu_result),
    .busy       (busy),
    .op_count   (op_count)
  );

  // ALU8 stand-in
  always_comb begin
    alu_result = 8'h00;
    case (alu_mode)
      2'd0: alu_result = alu_left & alu_right;
      2'd1: alu_result = alu_left | alu_right;
      2'd2: alu_result = alu_left + alu_right;
      2'd3: alu_result = alu_left - alu_right;
      default: alu_result = 8'h00;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_byte(input logic [7:0] d, input logic [1:0] m);
    int guard;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_mode  = m;
    guard = 0;
    while (!bus.in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_val("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  logic [7:0] exp_res;
  logic [7:0] exp_cnt;
  logic [3:0] modes_seen;
  logic [7:0] lb;
  logic [1:0] m;

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    reset_bar     = 1'b0;
    clear         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h77;
    bus.in_mode   = 2'd3;
    bus.res_ready = 1'b0;

    // ---------------- reset with in_valid held high
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check_val("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    check_val("rst_busy",      {31'd0, busy},          32'd0);
    check_val("rst_res_data",  {24'd0, bus.res_data},  32'h00);
    check_val("rst_res_zero",  {31'd0, bus.res_zero},  32'd0);
    check_val("rst_alu_left",  {24'd0, alu_left},      32'h00);
    check_val("rst_alu_right", {24'd0, alu_right},     32'h00);
    check_val("rst_alu_mode",  {30'd0, alu_mode},      32'd0);
    check_val("rst_op_count",  {24'd0, op_count},      32'd0);
    bus.in_valid = 1'b0;
    reset_bar    = 1'b1;
    @(negedge clk);
    check_val("post_rst_busy", {31'd0, busy}, 32'd0);

    // ---------------- basic op: A6 + 6A (mode 2) = 0x10
    bus.res_ready = 1'b1;
    send_byte(8'hA6, 2'd3);          // mode ignored with the left byte
    check_val("basic_left",      {24'd0, alu_left}, 32'hA6);
    check_val("basic_mode_hold", {30'd0, alu_mode}, 32'd0);
    check_val("basic_busy_r",    {31'd0, busy},     32'd1);
    send_byte(8'h6A, 2'd2);          // now in S_EXEC
    check_val("basic_exec_rv",   {31'd0, bus.res_valid}, 32'd0);
    check_val("basic_exec_rdy",  {31'd0, bus.in_ready},  32'd0);
    check_val("basic_right",     {24'd0, alu_right},     32'h6A);
    check_val("basic_mode",      {30'd0, alu_mode},      32'd2);
    @(negedge clk);                  // S_DONE, two cycles after right byte
    check_val("basic_res_valid", {31'd0, bus.res_valid}, 32'd1);
    check_val("basic_res_data",  {24'd0, bus.res_data},  32'h10);
    check_val("basic_res_zero",  {31'd0, bus.res_zero},  32'd0);
    check_val("basic_cnt_pre",   {24'd0, op_count},      32'd0);
    @(negedge clk);
    check_val("basic_rv_drop",   {31'd0, bus.res_valid}, 32'd0);
    check_val("basic_op_count",  {24'd0, op_count},      32'd1);
    check_val("basic_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check_val("basic_res_keep",  {24'd0, bus.res_data},  32'h10);

    // ---------------- zero result with backpressure: 80 + 80 = 0x00
    bus.res_ready = 1'b0;
    send_byte(8'h80, 2'd0);
    send_byte(8'h80, 2'd2);
    bus.in_valid = 1'b1;             // offered byte must not be consumed
    bus.in_data  = 8'h55;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_val("bp_res_valid", {31'd0, bus.res_valid}, 32'd1);
      check_val("bp_res_data",  {24'd0, bus.res_data},  32'h00);
      check_val("bp_res_zero",  {31'd0, bus.res_zero},  32'd1);
      check_val("bp_in_ready",  {31'd0, bus.in_ready},  32'd0);
      check_val("bp_op_count",  {24'd0, op_count},      32'd1);
    end
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    check_val("bp_release_cnt", {24'd0, op_count},      32'd2);
    check_val("bp_release_rv",  {31'd0, bus.res_valid}, 32'd0);
    check_val("bp_left_kept",   {24'd0, alu_left},      32'h80);

    // ---------------- gapped input: 0F & 3C = 0x0C
    send_byte(8'h0F, 2'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("gap_busy",     {31'd0, busy},          32'd1);
      check_val("gap_in_ready", {31'd0, bus.in_ready},  32'd1);
      check_val("gap_rv",       {31'd0, bus.res_valid}, 32'd0);
    end
    send_byte(8'h3C, 2'd0);
    @(negedge clk);
    check_val("gap_res_data", {24'd0, bus.res_data},  32'h0C);
    check_val("gap_res_zero", {31'd0, bus.res_zero},  32'd0);
    @(negedge clk);
    check_val("gap_op_count", {24'd0, op_count}, 32'd3);

    // ---------------- clear in S_EXEC: result never captured
    send_byte(8'h11, 2'd0);
    send_byte(8'h22, 2'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check_val("clr_exec_rv",    {31'd0, bus.res_valid}, 32'd0);
    check_val("clr_exec_ready", {31'd0, bus.in_ready},  32'd1);
    check_val("clr_exec_busy",  {31'd0, busy},          32'd0);
    check_val("clr_exec_data",  {24'd0, bus.res_data},  32'h0C);
    check_val("clr_exec_cnt",   {24'd0, op_count},      32'd3);
    check_val("clr_exec_left",  {24'd0, alu_left},      32'h11);
    @(negedge clk);
    check_val("clr_exec_idle",  {31'd0, bus.res_valid}, 32'd0);

    // ---------------- clear in S_DONE with res_ready high: 05 - 03 = 02
    send_byte(8'h05, 2'd0);
    send_byte(8'h03, 2'd3);
    @(negedge clk);
    check_val("clr_done_rv",   {31'd0, bus.res_valid}, 32'd1);
    check_val("clr_done_data", {24'd0, bus.res_data},  32'h02);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check_val("clr_done_cnt",   {24'd0, op_count},      32'd3);
    check_val("clr_done_rv2",   {31'd0, bus.res_valid}, 32'd0);
    check_val("clr_done_ready", {31'd0, bus.in_ready},  32'd1);
    check_val("clr_done_keep",  {24'd0, bus.res_data},  32'h02);

    // ---------------- 256 operations: counter wrap, all modes
    exp_cnt    = 8'd3;
    modes_seen = 4'b0000;
    for (int i = 0; i < 256; i++) begin
      lb = i[7:0];
      m  = i[1:0];
      case (m)
        2'd0: exp_res = lb & 8'h01;
        2'd1: exp_res = lb | 8'h01;
        2'd2: exp_res = lb + 8'h01;
        default: exp_res = lb - 8'h01;
      endcase
      send_byte(lb, 2'd0);
      send_byte(8'h01, m);
      check_val("wrap_mode", {30'd0, alu_mode}, {30'd0, m});
      modes_seen[alu_mode] = 1'b1;
      @(negedge clk);
      check_val("wrap_res_data", {24'd0, bus.res_data}, {24'd0, exp_res});
      @(negedge clk);
      exp_cnt = exp_cnt + 8'd1;
      check_val("wrap_op_count", {24'd0, op_count}, {24'd0, exp_cnt});
      if (i == 251) check_val("wrap_cnt_ff", {24'd0, op_count}, 32'hFF);
      if (i == 252) check_val("wrap_cnt_00", {24'd0, op_count}, 32'h00);
    end
    check_val("wrap_modes_seen", {28'd0, modes_seen}, 32'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
